// File: rtl/full_adder_core.sv
// full_adder_core: registered ripple-carry adder of chained 1-bit full-adder cells
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign c[0] = Cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= c[WIDTH];
        Ovf  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: directed table-driven checks of 1-bit and 8-bit adder instances
module tb_full_adder_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a1, b1, cin1, iv1, sum1, cout1, ovf1, ov1;
  logic [7:0] a8, b8, sum8;
  logic       cin8, iv8, cout8, ovf8, ov8;

  full_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(iv1),
    .Sum(sum1), .Cout(cout1), .Ovf(ovf1), .out_valid(ov1)
  );
  full_adder_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .in_valid(iv8),
    .Sum(sum8), .Cout(cout8), .Ovf(ovf8), .out_valid(ov8)
  );

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t v1[8];
  vec_t v8[5];
  int   valid_run;

  initial begin
    // {a,b,cin} -> {sum,cout,ovf}; 1-bit Ovf is Cout^Cin
    v1[0] = '{0, 0, 0, 0, 0, 0};
    v1[1] = '{0, 1, 0, 1, 0, 0};
    v1[2] = '{1, 0, 0, 1, 0, 0};
    v1[3] = '{1, 1, 0, 0, 1, 1};
    v1[4] = '{0, 0, 1, 1, 0, 1};
    v1[5] = '{0, 1, 1, 0, 1, 0};
    v1[6] = '{1, 0, 1, 0, 1, 0};
    v1[7] = '{1, 1, 1, 1, 1, 0};
    v8[0] = '{8'hFF, 8'h01, 0, 8'h00, 1, 0};
    v8[1] = '{8'hFF, 8'hFF, 1, 8'hFF, 1, 0};
    v8[2] = '{8'h7F, 8'h01, 0, 8'h80, 0, 1};
    v8[3] = '{8'h80, 8'h80, 0, 8'h00, 1, 1};
    v8[4] = '{8'h12, 8'h34, 1, 8'h47, 0, 0};

    a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; iv8 = 1;
    step();
    step();
    chk("rst_sum1", sum1, 0);
    chk("rst_cout1", cout1, 0);
    chk("rst_ovf1", ovf1, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_ov8", ov8, 0);
    rst = 0; iv8 = 0;

    for (int i = 0; i < 8; i++) begin
      a1 = v1[i].a[0]; b1 = v1[i].b[0]; cin1 = v1[i].cin; iv1 = 1;
      step();
      chk($sformatf("w1_sum[%0d]", i), sum1, v1[i].sum[0]);
      chk($sformatf("w1_cout[%0d]", i), cout1, v1[i].cout);
      chk($sformatf("w1_ovf[%0d]", i), ovf1, v1[i].ovf);
      chk($sformatf("w1_ov[%0d]", i), ov1, 1);
    end

    // reset with a valid operation pending: operation is dropped
    rst = 1; a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
    step();
    chk("w1_rst_sum", sum1, 0);
    chk("w1_rst_cout", cout1, 0);
    chk("w1_rst_ovf", ovf1, 0);
    chk("w1_rst_ov", ov1, 0);
    rst = 0; a1 = 1; b1 = 0; cin1 = 0;
    step();
    chk("w1_post_sum", sum1, 1);
    chk("w1_post_cout", cout1, 0);
    chk("w1_post_ov", ov1, 1);
    iv1 = 0;

    for (int i = 0; i < 5; i++) begin
      a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].cin; iv8 = 1;
      step();
      chk($sformatf("w8_sum[%0d]", i), sum8, v8[i].sum);
      chk($sformatf("w8_cout[%0d]", i), cout8, v8[i].cout);
      chk($sformatf("w8_ovf[%0d]", i), ovf8, v8[i].ovf);
      chk($sformatf("w8_ov[%0d]", i), ov8, 1);
    end

    // hold: last capture was 0x12+0x34+1
    iv8 = 0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin a8 = 'x; b8 = 'x; cin8 = 'x; end
      step();
      chk($sformatf("hold_sum[%0d]", i), sum8, 8'h47);
      chk($sformatf("hold_cout[%0d]", i), cout8, 0);
      chk($sformatf("hold_ov[%0d]", i), ov8, 0);
    end

    valid_run = 0;
    for (int i = 0; i < 100; i++) begin
      logic [8:0] full;
      logic       exp_ovf;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1;
      full = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
      exp_ovf = (a8[7] == b8[7]) && (full[7] != a8[7]);
      step();
      chk($sformatf("tp_sum[%0d]", i), sum8, full[7:0]);
      chk($sformatf("tp_cout[%0d]", i), cout8, full[8]);
      chk($sformatf("tp_ovf[%0d]", i), ovf8, exp_ovf);
      if (ov8 === 1'b1) valid_run++;
    end
    chk("tp_valid_run", valid_run, 100);
    iv8 = 0;
    step();
    chk("tp_ov_drop", ov8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/full_adder_core.md
Name: full_adder_core

Overview:
- Registered ripple-carry adder built from 1-bit full-adder cells. It computes Sum/Cout of A + B + Cin.
- With WIDTH=1 it is the classic single-bit full adder, with outputs captured on the clock.
- It is the arithmetic primitive used by the datapath/ALU of the RISC core. Clock and reset are shared with the core.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A, unsigned (also interpreted as two's-complement for Ovf).
- B  input  WIDTH  operand B, same interpretation as A.
- Cin  input  1  carry in, weight 2^0.
- in_valid  input  1  operands valid this cycle; the result is captured only when high.
- Sum  output  WIDTH  registered low WIDTH bits of A+B+Cin.
- Cout  output  1  registered carry out of bit WIDTH-1.
- Ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  high for exactly the cycle after a captured operation.

Behaviour:
- Combinational core: WIDTH chained 1-bit full-adder cells.
  - Per bit: s[i] = a[i]^b[i]^c[i]; c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]); c[0] = Cin.
  - Cout = c[WIDTH]; Ovf = c[WIDTH]^c[WIDTH-1]. For WIDTH=1, c[0] is Cin, so Ovf = Cout^Cin.
- Arithmetic: {Cout,Sum} equals the unsigned (WIDTH+1)-bit value A+B+Cin. There is no saturation; the result wraps modulo 2^WIDTH with the carry in Cout.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on Sum/Cout/Ovf after edge N and are stable until the next capture.
- Capture rule:
  - If rst is high at an edge: Sum=0, Cout=0, Ovf=0, out_valid=0, regardless of in_valid.
  - Else if in_valid is high: Sum/Cout/Ovf load the new result and out_valid=1.
  - Else: Sum/Cout/Ovf hold their previous values and out_valid=0.
- Back-to-back: in_valid may stay high every cycle. Full throughput is one result per clock with no bubbles and no backpressure.
- Reset mid-operation: an operation presented in the same cycle as rst is discarded. The first valid result after reset appears one cycle after the first edge with rst=0 and in_valid=1.
- Power-up: register values before the first reset are undefined. Verification starts after at least one reset cycle.
- No combinational path from any input to any output.
- X on inputs while in_valid=0 must not corrupt the held outputs.

Test Plan:
- Exhaustive 1-bit (WIDTH=1), applying in_valid=1 and one vector per cycle (A,B,Cin) = 000,010,100,110,001,011,101,111.
  - Required Sum/Cout one cycle later: 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
  - out_valid is high on each result cycle.
- Reset (WIDTH=1): after Sum=1/Cout=1, assert rst for 1 cycle with A=1, B=1, Cin=1, in_valid=1.
  - Required next cycle: Sum=0, Cout=0, Ovf=0, out_valid=0.
  - After deasserting rst, A=1, B=0, Cin=0 gives Sum=1, Cout=0.
- Hold (WIDTH=8): capture A=0x12, B=0x34, Cin=1, giving Sum=0x47, Cout=0.
  - Then drive in_valid=0 with A=0xFF, B=0xFF for 3 cycles.
  - Required: Sum stays 0x47, Cout stays 0, out_valid=0 during the hold.
- Wrap and carry (WIDTH=8): A=0xFF, B=0x01, Cin=0 gives Sum=0x00, Cout=1, Ovf=0. A=0xFF, B=0xFF, Cin=1 gives Sum=0xFF, Cout=1, Ovf=0.
- Signed overflow (WIDTH=8): A=0x7F, B=0x01, Cin=0 gives Sum=0x80, Cout=0, Ovf=1. A=0x80, B=0x80, Cin=0 gives Sum=0x00, Cout=1, Ovf=1.
- Throughput (WIDTH=8): 100 consecutive random vectors with in_valid=1.
  - Each result matches A+B+Cin of the previous cycle.
  - out_valid stays high for 100 consecutive cycles.
